mdr_mem_if: RTL and testbench
=============================

# mdr_mem_if

Memory-interface stage for the mini CPU datapath. It holds the MAR and MDR and runs read/write transactions to the external RAM over a req/ack handshake. Its MDR value drives the bus multiplexer's MDR input, and it loads from the bus output. Control-unit strobes start transactions; the block reports completion with a one-cycle `done` pulse and flags timeouts.

## Interface
Parameters:
- `DATA_W`, 32, data width of bus, MDR and RAM data.
- `ADDR_W`, 9, RAM address width; MAR holds `BusMuxOut[ADDR_W-1:0]`.
- `TIMEOUT`, 16, number of request cycles without `mem_ack` before abort (≥2).

Ports:
- `clock` in 1: sole clock, rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `BusMuxOut` in DATA_W: bus value, source for MAR/MDR loads.
- `MARin` in 1: load MAR from bus.
- `MDRin` in 1: load MDR from bus.
- `mem_read` in 1: start-read strobe.
- `mem_write` in 1: start-write strobe.
- `BusMuxInMDR` out DATA_W: MDR contents, to bus mux.
- `mem_req` out 1: RAM request.
- `mem_we` out 1: RAM write enable, valid with `mem_req`.
- `mem_addr` out ADDR_W: RAM address, equals MAR.
- `mem_wdata` out DATA_W: RAM write data, equals MDR.
- `mem_rdata` in DATA_W: RAM read data, valid when `mem_ack`=1.
- `mem_ack` in 1: RAM completion, one cycle.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `mem_err` out 1: last transaction timed out, sticky.

## Operation
- Reset values (edge with `clear`=1): state IDLE, MAR=0, MDR=0, counter=0, `mem_req`=`mem_we`=`busy`=`done`=`mem_err`=0. `clear` overrides every other input, including mid-transaction. The request drops after that edge; a late `mem_ack` is then ignored.
- States are IDLE, RD and WR.
  - `mem_req`=1 in RD and WR. `mem_we`=1 only in WR. `busy`=1 in RD and WR.
- Transitions:
  - IDLE with `mem_read`=1 → RD.
  - IDLE with `mem_write`=1 (and `mem_read`=0) → WR.
  - Both strobes in the same cycle: the read wins and the write is dropped.
  - RD or WR with `mem_ack`=1 → IDLE, `done` pulse.
    - In RD, MDR←`mem_rdata` on the same edge.
  - RD or WR with timeout reached and no ack → IDLE, `done` pulse, `mem_err`=1; MDR unchanged.
- `mem_err` clears on the next accepted start or on `clear`. It stays 1 otherwise.
- Timeout counter:
  - Zeroed on entry to RD/WR.
  - Increments on each request cycle without ack.
  - Abort fires at the edge ending the TIMEOUT-th request cycle with no ack.
  - An ack in that same cycle is a success.
- Loads in IDLE:
  - `MARin` loads MAR.
  - `MDRin` loads MDR.
  - Both may load in the same cycle.
  - A load in the same cycle as a start strobe is applied first, and the transaction uses the new value.
- While `busy`=1: `MARin`, `MDRin`, `mem_read` and `mem_write` are ignored. MAR and MDR are owned by the transaction.
- `mem_ack` is ignored in IDLE.

## Timing
- Start strobe sampled at edge k. `mem_req` is high from cycle k+1.
- Ack sampled at edge k+1+w, where w is the number of extra wait cycles, w≥0. At that edge MDR is updated (read) and the state returns to IDLE. `done`=1 during the following cycle.
- Minimum latency is start edge to `done` high = 2 cycles.
- `done` is registered and high exactly one cycle. A new start is accepted in the same cycle that `done` is high (back-to-back transactions).
- `mem_addr` and `mem_wdata` are stable for the whole request.
- All outputs are registered or decoded from registered state only. There is no combinational path from `mem_ack` to any output.

## Structure
- Shared package `mini_cpu_pkg`: state encoding constants (IDLE, RD, WR), default `DATA_W` and `ADDR_W`.
- One sub-module, `mem_timeout_counter`: clear-on-entry, increment, and terminal flag at `TIMEOUT`-1.
- MAR/MDR registers and the FSM live in `mdr_mem_if`.

## Test plan
- Read, zero wait: bus=0x5, `MARin`; then `mem_read`. Ack with `mem_rdata`=0xDEADBEEF in the first request cycle → `mem_addr`=5, `mem_we`=0, `BusMuxInMDR`=0xDEADBEEF, `done` 2 cycles after start.
- Write, 3 waits: MDR←0x12345678 from bus, MAR←0x1FF; `mem_write`, ack after 3 waits → `mem_we`=1, `mem_wdata`=0x12345678, `mem_addr`=0x1FF for 4 cycles; `done` pulse; `mem_err`=0.
- Timeout: `mem_read` with no ack, TIMEOUT=16 → `mem_req` high 16 cycles; `done` and `mem_err`=1; MDR unchanged. Next `mem_write` clears `mem_err`.
- Ack on the last allowed cycle, request cycle 16 → success, `mem_err`=0.
- Simultaneous `mem_read`+`mem_write`, plus `MDRin` with bus=0xAA while busy → read performed, MDR not loaded with 0xAA, no write issued.
- `clear` on the 2nd request cycle, followed by a stray `mem_ack` → all outputs 0, no `done`, MDR=0.

Source files
------------

// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: shared datapath widths and memory-interface state encoding.
package mini_cpu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} memState_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts unacknowledged request cycles, flags the last allowed one.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  input  logic step,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] count;
  always_ff @(posedge clock) begin
    if (clear || restart) count <= '0;
    else if (step) count <= count + 1'b1;
  end
  assign expired = count == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mdr_mem_if.sv
// mdr_mem_if: MAR/MDR registers and req/ack RAM transaction FSM with timeout.
module mdr_mem_if
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              mem_err
);
  memState_t state, nextState;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic idle, start, finish, expired;
  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) timeoutCounter (
    .clock(clock),
    .clear(clear),
    .restart(start),
    .step(busy && !mem_ack),
    .expired(expired)
  );
  always_comb begin
    idle = state == IDLE;
    start = idle && (mem_read || mem_write);
    finish = !idle && (mem_ack || expired);
    nextState = start ? (mem_read ? RD : WR) : finish ? IDLE : state;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      mar <= '0;
      mdr <= '0;
      done <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state <= nextState;
      done <= finish;
      if (idle && MARin) mar <= BusMuxOut[ADDR_W-1:0];
      if (idle && MDRin) mdr <= BusMuxOut;
      else if (state == RD && mem_ack) mdr <= mem_rdata;
      // an ack on the terminal cycle still counts as success
      if (start) mem_err <= 1'b0;
      else if (finish && !mem_ack) mem_err <= 1'b1;
    end
  end
  assign mem_req = !idle;
  assign busy = !idle;
  assign mem_we = state == WR;
  assign mem_addr = mar;
  assign mem_wdata = mdr;
  assign BusMuxInMDR = mdr;
endmodule

// File: tb/tb_mdr_mem_if.sv
// tb_mdr_mem_if: randomized and directed checks of mdr_mem_if against a transaction-level model.
module tb_mdr_mem_if;
  localparam int TIMEOUT = 16;
  logic clock = 0, clear = 1;
  logic [31:0] BusMuxOut = 0, mem_rdata = 0, BusMuxInMDR, mem_wdata;
  logic MARin = 0, MDRin = 0, mem_read = 0, mem_write = 0, mem_ack = 0;
  logic mem_req, mem_we, busy, done, mem_err;
  logic [8:0] mem_addr;
  int total = 0, bad = 0;
  logic [8:0] mMar = 0;
  logic [31:0] mMdr = 0;

  mdr_mem_if #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .mem_read(mem_read), .mem_write(mem_write), .BusMuxInMDR(BusMuxInMDR),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic load(input bit ma, input bit md, input logic [31:0] v);
    BusMuxOut = v; MARin = ma; MDRin = md;
    @(negedge clock);
    MARin = 0; MDRin = 0;
    if (ma) mMar = v[8:0];
    if (md) mMdr = v;
  endtask

  // drives one transaction starting at the current negedge; returns at the negedge where done is seen
  task automatic txn(input bit rd, input bit wr, input int ackAt, input logic [31:0] rdata, input bit junk,
                     output int reqCyc, output int doneLat, output int addrBad, output int weOnes);
    reqCyc = 0; doneLat = 0; addrBad = 0; weOnes = 0;
    mem_read = rd; mem_write = wr;
    for (int n = 1; n <= TIMEOUT + 4; n++) begin
      @(negedge clock);
      mem_read = 0; mem_write = 0; MARin = 0; MDRin = 0;
      if (mem_req) begin
        reqCyc++;
        if (mem_addr !== mMar || mem_wdata !== mMdr) addrBad++;
        weOnes += int'(mem_we);
      end
      if (done) begin
        doneLat = n; mem_ack = 0;
        return;
      end
      mem_ack = n == ackAt;
      mem_rdata = n == ackAt ? rdata : $urandom;
      if (junk) begin
        MARin = 1; MDRin = 1; BusMuxOut = 32'hAA; mem_read = 1; mem_write = 1;
      end
    end
    mem_ack = 0;
  endtask

  // compares one finished transaction against what the rules predict; updates the model
  task automatic judge(input string name, input bit rd, input bit wr, input int ackAt, input logic [31:0] rdata,
                       input int reqCyc, input int doneLat, input int addrBad, input int weOnes);
    int expReq;
    expReq = ackAt == 0 ? TIMEOUT : ackAt;
    if (rd && ackAt != 0) mMdr = rdata;
    total++; if (reqCyc !== expReq) begin bad++; $display("FAIL %s req_cycles got=%0d want=%0d", name, reqCyc, expReq); end
    total++; if (doneLat !== expReq + 1) begin bad++; $display("FAIL %s done_latency got=%0d want=%0d", name, doneLat, expReq + 1); end
    total++; if (addrBad !== 0) begin bad++; $display("FAIL %s addr_wdata_unstable got=%0d want=0", name, addrBad); end
    total++; if (weOnes !== ((!rd && wr) ? expReq : 0)) begin bad++; $display("FAIL %s we_cycles got=%0d want=%0d", name, weOnes, (!rd && wr) ? expReq : 0); end
    total++; if (mem_err !== (ackAt == 0)) begin bad++; $display("FAIL %s mem_err got=%b want=%b", name, mem_err, ackAt == 0); end
    total++; if (BusMuxInMDR !== mMdr) begin bad++; $display("FAIL %s mdr got=%h want=%h", name, BusMuxInMDR, mMdr); end
  endtask

  task automatic test_reset();
    clear = 1;
    repeat (2) @(negedge clock);
    clear = 0;
    total++;
    if ({mem_req, mem_we, busy, done, mem_err, mem_addr, BusMuxInMDR} !== '0) begin
      bad++; $display("FAIL reset outputs got=%b%b%b%b%b %h %h want=all zero", mem_req, mem_we, busy, done, mem_err, mem_addr, BusMuxInMDR);
    end
  endtask

  task automatic test_read_zero_wait();
    int r, d, a, w;
    load(1, 0, 32'h5);
    txn(1, 0, 1, 32'hDEADBEEF, 0, r, d, a, w);
    judge("read0", 1, 0, 1, 32'hDEADBEEF, r, d, a, w);
    total++; if (mem_addr !== 9'h5) begin bad++; $display("FAIL read0 addr got=%h want=005", mem_addr); end
    @(negedge clock);
    total++; if (done !== 0) begin bad++; $display("FAIL read0 done_width got=%b want=0", done); end
  endtask

  task automatic test_write_waits();
    int r, d, a, w;
    load(0, 1, 32'h12345678);
    load(1, 0, 32'h1FF);
    txn(0, 1, 4, 0, 0, r, d, a, w);
    judge("write3", 0, 1, 4, 0, r, d, a, w);
  endtask

  task automatic test_timeout();
    int r, d, a, w;
    txn(1, 0, 0, 0, 0, r, d, a, w);
    judge("timeout", 1, 0, 0, 0, r, d, a, w);
    txn(0, 1, 2, 0, 0, r, d, a, w);
    judge("after_timeout", 0, 1, 2, 0, r, d, a, w);
  endtask

  task automatic test_last_cycle_ack();
    int r, d, a, w;
    txn(1, 0, TIMEOUT, 32'hCAFEF00D, 0, r, d, a, w);
    judge("last_ack", 1, 0, TIMEOUT, 32'hCAFEF00D, r, d, a, w);
  endtask

  task automatic test_simultaneous();
    int r, d, a, w;
    @(negedge clock);
    txn(1, 1, 3, 32'h0BADF00D, 1, r, d, a, w);
    judge("both_strobes", 1, 1, 3, 32'h0BADF00D, r, d, a, w);
  endtask

  task automatic test_back_to_back();
    int r, d, a, w;
    load(1, 1, 32'h00000123);
    txn(0, 1, 1, 0, 0, r, d, a, w);
    judge("b2b_first", 0, 1, 1, 0, r, d, a, w);
    txn(1, 0, 2, 32'h55AA55AA, 0, r, d, a, w);
    judge("b2b_second", 1, 0, 2, 32'h55AA55AA, r, d, a, w);
  endtask

  task automatic test_load_with_start();
    int r, d, a, w;
    BusMuxOut = 32'h00000077; MARin = 1; MDRin = 1;
    mMar = 9'h077; mMdr = 32'h77;
    txn(0, 1, 2, 0, 0, r, d, a, w);
    judge("load_start", 0, 1, 2, 0, r, d, a, w);
  endtask

  task automatic test_clear_mid();
    mem_read = 1;
    @(negedge clock);
    mem_read = 0;
    @(negedge clock);
    clear = 1;
    @(negedge clock);
    clear = 0; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clock);
    mem_ack = 0;
    mMar = 0; mMdr = 0;
    total++;
    if ({mem_req, mem_we, busy, done, mem_err} !== 5'b0) begin
      bad++; $display("FAIL clear_mid ctrl got=%b%b%b%b%b want=00000", mem_req, mem_we, busy, done, mem_err);
    end
    total++; if (BusMuxInMDR !== 32'h0 || mem_addr !== 9'h0) begin bad++; $display("FAIL clear_mid regs got=%h/%h want=0/0", BusMuxInMDR, mem_addr); end
  endtask

  task automatic test_random();
    int r, d, a, w, ackAt, mode;
    logic [31:0] rdata;
    bit rd, wr;
    for (int i = 0; i < 24; i++) begin
      load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      mode = $urandom_range(0, 2);
      rd = mode != 1; wr = mode != 0;
      ackAt = $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, TIMEOUT);
      rdata = $urandom;
      txn(rd, wr, ackAt, rdata, 1'($urandom_range(0, 1)), r, d, a, w);
      judge("random", rd, wr, ackAt, rdata, r, d, a, w);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_timeout();
    test_last_cycle_ack();
    test_simultaneous();
    test_back_to_back();
    test_load_with_start();
    test_clear_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
